// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the two message sources, the shared uart_tx and the arbiter.
// The master side is the environment (requesters plus transmitter); the slave side is the arbiter.
interface uart_tx_arbiter_if #(
    parameter int DATASIZE = 128
);
    logic                req0;
    logic [DATASIZE-1:0] msg0;
    logic                ack0;
    logic                req1;
    logic [DATASIZE-1:0] msg1;
    logic                ack1;
    logic                tx_busy;
    logic                tx_en;
    logic [7:0]          tx_data;
    logic [1:0]          grant;
    logic                active;

    modport master (
        output req0, msg0, req1, msg1, tx_busy,
        input  ack0, ack1, tx_en, tx_data, grant, active
    );

    modport slave (
        input  req0, msg0, req1, msg1, tx_busy,
        output ack0, ack1, tx_en, tx_data, grant, active
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between two message sources.
// It latches the granted message and sends its nonzero bytes MSB first.
//
// state     | meaning
// S_IDLE    | no owner; pick a requester round-robin and latch its message
// S_LOAD    | examine byte[idx]; skip 0x00 bytes
// S_ISSUE   | wait for the transmitter to be free, then pulse tx_en
// S_WAIT_HI | wait for tx_busy to rise
// S_WAIT_LO | wait for tx_busy to fall, then advance to the next byte or finish
// S_DONE    | pulse the owner's ack and release the grant
module uart_tx_arbiter #(
    parameter int DATASIZE     = 128,
    parameter int PAYLOAD_BITS = 8
) (
    input logic            clk,
    input logic            reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int NBYTES = DATASIZE / PAYLOAD_BITS;
    localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_DONE
    } state_t;

    state_t state_q, state_nxt;
    logic [NBYTES-1:0][PAYLOAD_BITS-1:0] msg_buf_q, msg_buf_nxt;
    logic [IDXW-1:0] idx_q, idx_nxt, rev_idx;
    logic [PAYLOAD_BITS-1:0] cur_byte, tx_data_q, tx_data_nxt;
    logic tx_en_q, tx_en_nxt;
    logic ack0_q, ack0_nxt, ack1_q, ack1_nxt;
    logic [1:0] grant_q, grant_nxt;
    logic active_q, active_nxt;
    logic last_q, last_nxt;
    logic req0_ok, req1_ok;

    // idx counts from the MSB byte; the packed array is indexed LSB first.
    assign rev_idx  = LAST_IDX - idx_q;
    assign cur_byte = msg_buf_q[rev_idx];

    // A requester still showing its ack is dropping req on this edge; ignore it once.
    assign req0_ok = bus.req0 & ~ack0_q;
    assign req1_ok = bus.req1 & ~ack1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            msg_buf_q <= '0;
            idx_q     <= '0;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            grant_q   <= 2'b00;
            active_q  <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_nxt;
            msg_buf_q <= msg_buf_nxt;
            idx_q     <= idx_nxt;
            tx_data_q <= tx_data_nxt;
            tx_en_q   <= tx_en_nxt;
            ack0_q    <= ack0_nxt;
            ack1_q    <= ack1_nxt;
            grant_q   <= grant_nxt;
            active_q  <= active_nxt;
            last_q    <= last_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        msg_buf_nxt = msg_buf_q;
        idx_nxt     = idx_q;
        tx_data_nxt = tx_data_q;
        tx_en_nxt   = 1'b0;
        ack0_nxt    = 1'b0;
        ack1_nxt    = 1'b0;
        grant_nxt   = grant_q;
        active_nxt  = active_q;
        last_nxt    = last_q;
        case (state_q)
            S_IDLE: begin
                if (req0_ok && (!req1_ok || last_q)) begin
                    msg_buf_nxt = bus.msg0;
                    grant_nxt   = 2'b01;
                    active_nxt  = 1'b1;
                    idx_nxt     = '0;
                    last_nxt    = 1'b0;
                    state_nxt   = S_LOAD;
                end else if (req1_ok) begin
                    msg_buf_nxt = bus.msg1;
                    grant_nxt   = 2'b10;
                    active_nxt  = 1'b1;
                    idx_nxt     = '0;
                    last_nxt    = 1'b1;
                    state_nxt   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cur_byte != '0) begin
                    tx_data_nxt = cur_byte;
                    state_nxt   = S_ISSUE;
                end else if (idx_q == LAST_IDX) begin
                    state_nxt = S_DONE;
                end else begin
                    idx_nxt = idx_q + 1'b1;
                end
            end
            S_ISSUE: begin
                if (!bus.tx_busy) begin
                    tx_en_nxt = 1'b1;
                    state_nxt = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (bus.tx_busy) state_nxt = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!bus.tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        state_nxt = S_DONE;
                    end else begin
                        idx_nxt   = idx_q + 1'b1;
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                ack0_nxt   = grant_q[0];
                ack1_nxt   = grant_q[1];
                grant_nxt  = 2'b00;
                active_nxt = 1'b0;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.tx_en   = tx_en_q;
    assign bus.tx_data = tx_data_q;
    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.grant   = grant_q;
    assign bus.active  = active_q;
endmodule
